// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with configurable framing, sticky error flags and a
// show-ahead receive FIFO.
//
// Optional build macro:
//   UART_RX_GLITCH_FILTER_EN - majority-vote the synchronised line over three
//                              consecutive samples. This rejects single-cycle pulses
//                              and adds one cycle to every latency.
//
// Decision timing: each bit is sampled at its mid-point. The accept/discard decision
// for a frame is taken at the mid-point of its last stop bit, so the receiver is
// ready for the next start bit half a bit early.

module uart_rx_fifo #(
  parameter int unsigned CLK_HZ    = 25000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  input  logic                       clr_err
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CntW  = $clog2(DIV);
  localparam int unsigned AddrW = $clog2(DEPTH);

  localparam logic [CntW-1:0]  CntMax   = CntW'(DIV - 1);
  // Preload so that the first tick lands DIV/2 cycles after the start edge.
  localparam logic [CntW-1:0]  CntLoad  = CntW'(DIV - DIV / 2);
  localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
  localparam logic [AddrW:0]   CntFull  = {1'b1, {AddrW{1'b0}}};
  localparam logic [AddrW:0]   CntOne   = {{AddrW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_line;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] filt_q;

  // History of the two previous synchronised samples for the majority window.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 2'b11;
    end else begin
      filt_q <= {filt_q[0], sync_q[1]};
    end
  end

  // Majority of the current sample and the two before it: a one-cycle pulse
  // never wins, a real edge gets through one cycle later.
  assign rx_line = (sync_q[1] & filt_q[0]) | (sync_q[1] & filt_q[1]) |
                   (filt_q[0] & filt_q[1]);
`else
  assign rx_line = sync_q[1];
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   par_bad_q, par_bad_d;
  logic                   tick;
  logic                   push;
  logic                   frame_ev;
  logic                   parity_ev;

  assign tick = (cnt_q == CntMax);

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Next-state, bit sampling and frame decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    frame_ev  = 1'b0;
    parity_ev = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_line) begin
          state_d = StStart;
          cnt_d   = CntLoad;
        end
      end

      StStart: begin
        if (tick) begin
          if (rx_line) begin
            // Line back high at mid-bit: treat as noise.
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_d     = '0;
            par_d     = 1'b0;
            par_bad_d = 1'b0;
          end
        end
      end

      StData: begin
        if (tick) begin
          shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_line;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      StParity: begin
        if (tick) begin
          state_d = StStop;
          // Odd parity wants an overall XOR of 1, even parity wants 0.
          if (PARITY == 1) begin
            par_bad_d = ~(par_q ^ rx_line);
          end else begin
            par_bad_d = par_q ^ rx_line;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (!rx_line) begin
            frame_ev = 1'b1;
            state_d  = StBreak;
          end else if (bit_q == StopLast) begin
            state_d = StIdle;
            if (par_bad_q) begin
              parity_ev = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      StBreak: begin
        // Hold off until the line recovers so a long low is not read as a start bit.
        cnt_d = '0;
        if (rx_line) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]       count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 pop;
  logic                 do_push;
  logic                 overrun_ev;

  assign pop        = rd_en & ~empty_q;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push    = push & (~full_q | pop);
  assign overrun_ev = push & full_q & ~pop;

  // Pointer, occupancy and registered head-word update.
  always_comb begin
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (do_push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !do_push) begin
      count_d = count_q - 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CntFull);

    // When nothing older remains after this cycle's pop, the new head is the word
    // being pushed now, which is not yet in the array.
    if (empty_q || (pop && (count_q == CntOne))) begin
      if (do_push) begin
        rd_data_d = shift_q;
      end
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic frame_err_q, parity_err_q, overrun_q;

  // A new event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= (frame_err_q & ~clr_err) | frame_ev;
      parity_err_q <= (parity_err_q & ~clr_err) | parity_ev;
      overrun_q    <= (overrun_q & ~clr_err) | overrun_ev;
    end
  end

  assign rd_data    = rd_data_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: three instances (default 8N1/16-deep, 8N1/4-deep, and
// even-parity/4-deep, the latter two at 16 clocks per bit) driven by one shared
// serial line generator.

module tb_uart_rx_fifo;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif
  // 217*9 + 108 + 2 at the defaults, 16*9 + 8 + 2 for the fast instances.
  localparam int ExpLat0 = 2063 + Extra;
  localparam int ExpLat1 = 154 + Extra;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr_err, line;
  int   line_sel;
  logic rx0, rx1, rx2;
  logic rd_en0, rd_en1, rd_en2;

  assign rx0 = (line_sel == 0) ? line : 1'b1;
  assign rx1 = (line_sel == 1) ? line : 1'b1;
  assign rx2 = (line_sel == 2) ? line : 1'b1;

  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic       empty0, empty1, empty2, full0, full1, full2;
  logic [4:0] count0;
  logic [2:0] count1, count2;
  logic       ferr0, ferr1, ferr2, perr0, perr1, perr2, ovr0, ovr1, ovr2;

  uart_rx_fifo u0 (
    .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0),
    .full(full0), .count(count0), .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0),
    .clr_err(clr_err)
  );

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1), .empty(empty1),
    .full(full1), .count(count1), .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1),
    .clr_err(clr_err)
  );

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .PARITY(2), .DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .rx(rx2), .rd_en(rd_en2), .rd_data(rd_data2), .empty(empty2),
    .full(full2), .count(count2), .frame_err(ferr2), .parity_err(perr2), .overrun(ovr2),
    .clr_err(clr_err)
  );

  int checks = 0;
  int errors = 0;

  // Push-latency monitor for u0: cycles from the start-bit edge to the count update.
  int cyc = 0;
  int t0  = 0;
  int lat = -1;
  bit armed = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (armed && count0 != 5'd0) begin
      lat   = cyc - t0 - 1;
      armed = 1'b0;
    end
  end

  // All stimulus changes on the falling edge.
  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int sel, input int div, input logic [8:0] data, input int nbits,
                      input int par_mode, input bit flip_par, input int stop_low);
    logic p;
    p = 1'b0;
    line_sel = sel;
    drive(1'b0, div);
    for (int i = 0; i < nbits; i++) begin
      drive(data[i], div);
      p = p ^ data[i];
    end
    if (par_mode != 0) drive(((par_mode == 1) ? ~p : p) ^ flip_par, div);
    if (stop_low > 0) drive(1'b0, stop_low * div);
    drive(1'b1, div);
  endtask

  task automatic pop(input int sel);
    case (sel)
      0: rd_en0 = 1'b1;
      1: rd_en1 = 1'b1;
      default: rd_en2 = 1'b1;
    endcase
    @(negedge clk);
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
    rd_en2 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count0); end
    checks++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b want 10", empty0, full0); end
    checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data0); end
    checks++; if ({ferr0, perr0, ovr0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ferr0, perr0, ovr0}); end
    checks++; if (empty1 !== 1'b1 || empty2 !== 1'b1) begin errors++; $display("FAIL reset_empty_small got %b%b want 11", empty1, empty2); end
  endtask

  task automatic test_8n1();
    lat = -1;
    t0 = cyc;
    armed = 1'b1;
    send(0, 217, 9'h0A5, 8, 0, 0, 0);
    send(0, 217, 9'h03C, 8, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (lat !== ExpLat0) begin errors++; $display("FAIL push_latency got %0d want %0d", lat, ExpLat0); end
    checks++; if (count0 !== 5'd2) begin errors++; $display("FAIL 8n1_count got %0d want 2", count0); end
    checks++; if (rd_data0 !== 8'hA5) begin errors++; $display("FAIL 8n1_head got %h want a5", rd_data0); end
    checks++; if ({ferr0, perr0, ovr0} !== 3'b000) begin errors++; $display("FAIL 8n1_flags got %b want 000", {ferr0, perr0, ovr0}); end
    pop(0);
    checks++; if (rd_data0 !== 8'h3C || count0 !== 5'd1) begin errors++; $display("FAIL 8n1_second got %h/%0d want 3c/1", rd_data0, count0); end
    pop(0);
    checks++; if (empty0 !== 1'b1 || count0 !== 5'd0) begin errors++; $display("FAIL 8n1_drained got %b/%0d want 1/0", empty0, count0); end
  endtask

  task automatic test_overrun();
    for (int v = 1; v <= 5; v++) send(1, 16, 9'(v), 8, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (full1 !== 1'b1 || count1 !== 3'd4) begin errors++; $display("FAIL ovr_full got %b/%0d want 1/4", full1, count1); end
    checks++; if (ovr1 !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", ovr1); end
    for (int v = 1; v <= 4; v++) begin
      checks++; if (rd_data1 !== 8'(v)) begin errors++; $display("FAIL ovr_read%0d got %h want %h", v, rd_data1, 8'(v)); end
      pop(1);
    end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL ovr_empty got %b want 1", empty1); end
    pulse_clr();
    checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ovr1); end
  endtask

  task automatic test_full_pop();
    for (int v = 8'h11; v <= 8'h14; v++) send(1, 16, 9'(v), 8, 0, 0, 0);
    checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL fp_full got %b want 1", full1); end
    fork
      send(1, 16, 9'h015, 8, 0, 0, 0);
      begin
        repeat (ExpLat1) @(negedge clk);
        rd_en1 = 1'b1;
        @(negedge clk);
        rd_en1 = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (count1 !== 3'd4 || full1 !== 1'b1) begin errors++; $display("FAIL fp_count got %0d/%b want 4/1", count1, full1); end
    checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL fp_overrun got %b want 0", ovr1); end
    for (int v = 8'h12; v <= 8'h15; v++) begin
      checks++; if (rd_data1 !== 8'(v)) begin errors++; $display("FAIL fp_read got %h want %h", rd_data1, 8'(v)); end
      pop(1);
    end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fp_empty got %b want 1", empty1); end
  endtask

  task automatic test_parity_frame();
    send(2, 16, 9'h055, 8, 2, 1, 0);
    repeat (2) @(negedge clk);
    checks++; if (perr2 !== 1'b1 || ferr2 !== 1'b0) begin errors++; $display("FAIL par_flag got p%b f%b want p1 f0", perr2, ferr2); end
    checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL par_empty got %b want 1", empty2); end
    send(2, 16, 9'h00F, 8, 2, 0, 3);
    repeat (2) @(negedge clk);
    checks++; if (ferr2 !== 1'b1 || perr2 !== 1'b1) begin errors++; $display("FAIL frm_flag got f%b p%b want f1 p1", ferr2, perr2); end
    checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL frm_empty got %b want 1", empty2); end
    send(2, 16, 9'h00F, 8, 2, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (count2 !== 3'd1 || rd_data2 !== 8'h0F) begin errors++; $display("FAIL par_valid got %0d/%h want 1/0f", count2, rd_data2); end
    pop(2);
    pulse_clr();
    checks++; if ({ferr2, perr2} !== 2'b00) begin errors++; $display("FAIL par_clear got %b want 00", {ferr2, perr2}); end
  endtask

  task automatic test_reset_mid_frame();
    send(0, 217, 9'h077, 8, 0, 0, 0);
    send(0, 217, 9'h000, 8, 0, 0, 2);
    repeat (2) @(negedge clk);
    checks++; if (count0 !== 5'd1 || ferr0 !== 1'b1) begin errors++; $display("FAIL rmf_setup got %0d/%b want 1/1", count0, ferr0); end
    fork
      send(0, 217, 9'h0FF, 8, 0, 0, 0);
      begin
        repeat (217 * 4 + 108) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (count0 !== 5'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL rmf_fifo got %0d/%b/%b want 0/1/0", count0, empty0, full0); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL rmf_rd_data got %h want 00", rd_data0); end
        checks++; if ({ferr0, perr0, ovr0} !== 3'b000) begin errors++; $display("FAIL rmf_flags got %b want 000", {ferr0, perr0, ovr0}); end
      end
    join
    repeat (217) @(negedge clk);
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL rmf_no_push got %0d want 0", count0); end
    send(0, 217, 9'h012, 8, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (count0 !== 5'd1 || rd_data0 !== 8'h12) begin errors++; $display("FAIL rmf_next got %0d/%h want 1/12", count0, rd_data0); end
    pop(0);
  endtask

  task automatic test_false_start();
    line_sel = 0;
    drive(1'b0, 1);
    drive(1'b1, 217 * 11);
    checks++; if (count0 !== 5'd0 || ferr0 !== 1'b0) begin errors++; $display("FAIL glitch1 got %0d/%b want 0/0", count0, ferr0); end
    drive(1'b0, 20);
    drive(1'b1, 217 * 11);
    checks++; if (count0 !== 5'd0 || {ferr0, perr0} !== 2'b00) begin errors++; $display("FAIL glitch20 got %0d/%b want 0/00", count0, {ferr0, perr0}); end
    send(0, 217, 9'h05A, 8, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (count0 !== 5'd1 || rd_data0 !== 8'h5A) begin errors++; $display("FAIL glitch_after got %0d/%h want 1/5a", count0, rd_data0); end
    pop(0);
  endtask

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    line = 1'b1;
    line_sel = 0;
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
    rd_en2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_overrun();
    test_full_pop();
    test_parity_frame();
    test_reset_mid_frame();
    test_false_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, error flags and optional input glitch filtering. Replaces the fixed 8N1, single-register receive path between the board `rx` pin and game logic such as the snake controller and the seven-segment display. Received words are buffered so that bursts of key presses are not lost while the consumer is busy. The consumer drains words through a show-ahead read port.

## Interface
- `CLK_HZ`, 25000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `DIV = (CLK_HZ + BAUD/2) / BAUD` clocks per bit, DIV ≥ 8.
- `DATA_BITS`, 8, word width, 5..9, LSB first on the line.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, 1 or 2.
- `DEPTH`, 16, FIFO depth, power of two, ≥ 2.

- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `rx` in 1 — asynchronous serial input, idle high.
- `rd_en` in 1 — pop the head word; ignored when `empty`.
- `rd_data` out DATA_BITS — head word, valid while `!empty`.
- `empty` out 1 — FIFO empty.
- `full` out 1 — FIFO full.
- `count` out $clog2(DEPTH)+1 — number of words stored.
- `frame_err` out 1 — sticky; a stop bit was sampled low.
- `parity_err` out 1 — sticky; parity mismatch.
- `overrun` out 1 — sticky; a word was dropped because the FIFO was full.
- `clr_err` in 1 — clears all three sticky flags.

## Operation
- `rx` passes through a 2-FF synchroniser; its reset value is 1.
- FSM states are IDLE, START, DATA, PARITY, STOP and BREAK. A bit counter counts 0..DIV-1.
- **IDLE:** on a synchronised low, go to START and load the counter to sample at DIV/2.
- **START:** at mid-bit, if the line is high (false start) return to IDLE. Otherwise go to DATA.
- **DATA:** take one sample every DIV clocks and shift it into the word, LSB first. After DATA_BITS samples, go to PARITY if `PARITY≠0`, else go to STOP.
- **PARITY:** sample the parity bit. Odd parity requires the XOR of data and parity bits to be 1; even parity requires it to be 0.
- **STOP:** sample each of the STOP_BITS stop bits at mid-bit.
  - If any stop bit is low: set `frame_err`, discard the word, and go to BREAK.
  - If all stop bits are high and parity failed: set `parity_err`, discard the word, and return to IDLE.
  - Otherwise push the word and return to IDLE.
  - The final decision is taken at the mid-point of the last stop bit, so the receiver is re-armed half a bit early.
- **BREAK:** wait until the line is high, then go to IDLE.
- **FIFO:** head-pointer show-ahead buffer, with a `count` register holding 0..DEPTH.
  - A push with `!full` writes the word.
  - A push with `full` and no pop in the same cycle drops the word and sets `overrun`.
  - A push and a pop in the same cycle while full both succeed, and `count` is unchanged.
  - A push and a pop in the same cycle while empty: the pop is ignored and the push succeeds.
  - Pointers wrap modulo DEPTH.
- `clr_err` clears the flags in the next cycle. If `clr_err` coincides with a new error event, the flag ends up set.
- **Reset** (any cycle, including mid-frame):
  - FSM returns to IDLE and pointers go to 0.
  - `count=0`, `empty=1`, `full=0`.
  - All error flags = 0 and `rd_data` = 0.
  - A partially received frame is discarded.

## Timing
- All outputs are registered. `empty`, `full`, `count` and `rd_data` update in the cycle after a push or pop.
- **Push latency:** the push occurs `DIV*(1+DATA_BITS+(PARITY≠0)+STOP_BITS-1) + DIV/2 + 2` clocks after the falling edge of the start bit at the pin. For 8N1 at the defaults this is 217·9+108+2 = 2063 cycles.
- `rd_en` is sampled on the clock edge; after a pop, the next word appears on `rd_data` one cycle later.

## Configuration
- **`UART_RX_GLITCH_FILTER_EN`**
  - **Defined:** the synchronised `rx` feeds a 3-sample shift register, and the FSM sees the majority vote. Single-cycle pulses on `rx` are rejected, and all latencies grow by 1 cycle (defaults give 2064).
  - **Undefined:** the FSM uses the synchroniser output directly, and a 1-cycle low pulse may start START. START still rejects it at mid-bit.

## Test plan
- **8N1 receive:** defaults; send 0xA5, then 0x3C. Then:
  - `count` = 2, `rd_data` = 0xA5, and no error flags.
  - One `rd_en` gives `rd_data` = 0x3C.
  - A second `rd_en` gives `empty` = 1.
- **Overrun:** DEPTH=4; send 5 words 0x01..0x05 without reading. Then:
  - `full` = 1, `overrun` = 1.
  - Reading returns 0x01..0x04.
  - `clr_err` clears `overrun`.
- **Parity and framing:** PARITY=2; send 0x55 with a wrong parity bit. Then send 0x0F with a low stop bit held low for 3 bit times, then release the line. Then:
  - `parity_err` = 1 and `frame_err` = 1.
  - FIFO remains empty.
  - A subsequent valid 0x0F is received correctly.
- **Full with simultaneous pop:** DEPTH=4, FIFO full; assert `rd_en` in the exact cycle of a push. Then `count` stays 4 and `overrun` = 0.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 3 of 0xFF. Then:
  - All outputs are at their reset values.
  - The remainder of the frame does not push a word.
  - The next 0x12 is received intact.
- **Glitch and false start:** with the filter macro defined, apply a 1-cycle low on idle `rx`; the FSM stays in IDLE. Without the macro, apply a 20-cycle low; the FSM returns to IDLE from START and nothing is pushed.
